// File: rtl/cc_pkg.sv
// Cache-controller shared definitions: AXI burst encodings, line-fill burst
// shape and miss-path FSM state type, used by the miss-request and fill stages.
package cc_pkg;

    localparam logic [1:0] CC_BURST_FIXED = 2'b00;
    localparam logic [1:0] CC_BURST_INCR  = 2'b01;
    localparam logic [1:0] CC_BURST_WRAP  = 2'b10;

    // 8 beats of 8 bytes cover one 64-byte line
    localparam logic [3:0] CC_ARLEN     = 4'd7;
    localparam logic [2:0] CC_ARSIZE    = 3'd3;
    localparam int         CC_MAX_OUTST = 4;

    typedef enum logic {
        IDLE,
        AR_REQ
    } miss_state_t;

    // Wrap burst starts on the doubleword holding the missed byte
    function automatic logic [31:0] cc_crit_dw_addr(input logic [31:0] addr);
        return {addr[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/cc_miss_req_unit_if.sv
// Miss-path signal bundle: miss request in, AXI AR channel out, miss-address
// FIFO push out and fill-completion pulse in.
interface cc_miss_req_unit_if;

    logic        miss_req_valid_i;
    logic [31:0] miss_req_addr_i;
    logic        miss_req_ready_o;

    logic        mem_arvalid_o;
    logic        mem_arready_i;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;

    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;

    logic        fill_done_i;

    modport master (
        input  miss_req_valid_i, miss_req_addr_i,
        output miss_req_ready_o,
        output mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
        input  mem_arready_i,
        input  miss_addr_fifo_full_i,
        output miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
        input  fill_done_i
    );

    modport slave (
        output miss_req_valid_i, miss_req_addr_i,
        input  miss_req_ready_o,
        input  mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o, mem_arburst_o,
        output mem_arready_i,
        output miss_addr_fifo_full_i,
        input  miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
        output fill_done_i
    );

endinterface

// File: rtl/cc_miss_req_unit.sv
// Miss request unit: accepts cache misses, issues one AXI wrap-burst AR at a time
// and pushes the miss address to the fill-stage FIFO, bounding fills in flight.
module cc_miss_req_unit
    import cc_pkg::*;
#(
    parameter int MAX_OUTST = CC_MAX_OUTST
) (
    input logic              clk,
    input logic              rst,
    cc_miss_req_unit_if.master bus
);

    miss_state_t state, state_nxt;
    logic [3:0]  outst_cnt;
    logic [31:0] araddr_q;
    logic        arvalid_q;
    logic        accept;

    // Ready is a function of registered state and the FIFO level only
    assign bus.miss_req_ready_o = !rst && (state == IDLE) && !bus.miss_addr_fifo_full_i
                                  && (outst_cnt < 4'(MAX_OUTST));
    assign accept = bus.miss_req_valid_i && bus.miss_req_ready_o;

    assign bus.miss_addr_fifo_wren_o  = accept;
    assign bus.miss_addr_fifo_wdata_o = bus.miss_req_addr_i;

    assign bus.mem_arvalid_o = arvalid_q;
    assign bus.mem_araddr_o  = araddr_q;
    assign bus.mem_arlen_o   = CC_ARLEN;
    assign bus.mem_arsize_o  = CC_ARSIZE;
    assign bus.mem_arburst_o = CC_BURST_WRAP;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = AR_REQ;
            AR_REQ:  if (bus.mem_arready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            outst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            arvalid_q <= (state_nxt == AR_REQ);
            if (accept) araddr_q <= cc_crit_dw_addr(bus.miss_req_addr_i);
            // Simultaneous accept and fill completion cancel out
            unique case ({accept, bus.fill_done_i})
                2'b10:   outst_cnt <= outst_cnt + 4'd1;
                2'b01:   if (outst_cnt != 4'd0) outst_cnt <= outst_cnt - 4'd1;
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Directed bench for cc_miss_req_unit: AR address scoreboard plus immediate
// checks on ready, FIFO push, burst attributes and the outstanding counter.
module tb_cc_miss_req_unit;
    import cc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] ar_q[$];
    logic [31:0] exp_addr;

    cc_miss_req_unit_if bus();

    cc_miss_req_unit #(.MAX_OUTST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a miss that must be accepted this cycle; leaves the unit in AR_REQ
    task automatic accept_miss(input logic [31:0] a, input logic with_fill);
        bus.miss_req_valid_i = 1'b1;
        bus.miss_req_addr_i  = a;
        bus.fill_done_i      = with_fill;
        #1;
        chk("acc_ready", 32'(bus.miss_req_ready_o), 32'd1);
        chk("acc_wren", 32'(bus.miss_addr_fifo_wren_o), 32'd1);
        chk("acc_wdata", bus.miss_addr_fifo_wdata_o, a);
        ar_q.push_back({a[31:3], 3'b000});
        tick();
        bus.miss_req_valid_i = 1'b0;
        bus.fill_done_i      = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.mem_arvalid_o), 32'd1);
        chk("ar_ready_low", 32'(bus.miss_req_ready_o), 32'd0);
    endtask

    task automatic ar_handshake();
        bus.mem_arready_i = 1'b1;
        #1;
        chk("hs_arvalid", 32'(bus.mem_arvalid_o), 32'd1);
        if (ar_q.size() == 0) begin
            chk("hs_sb_empty", 32'(ar_q.size()), 32'd1);
        end else begin
            exp_addr = ar_q.pop_front();
            chk("hs_araddr", bus.mem_araddr_o, exp_addr);
        end
        chk("hs_arlen", 32'(bus.mem_arlen_o), 32'd7);
        chk("hs_arsize", 32'(bus.mem_arsize_o), 32'd3);
        chk("hs_arburst", 32'(bus.mem_arburst_o), 32'd2);
        tick();
        bus.mem_arready_i = 1'b0;
        #1;
        chk("post_hs_arvalid", 32'(bus.mem_arvalid_o), 32'd0);
    endtask

    task automatic fill_pulse();
        bus.fill_done_i = 1'b1;
        tick();
        bus.fill_done_i = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.miss_req_valid_i      = 1'b0;
        bus.miss_req_addr_i       = '0;
        bus.mem_arready_i         = 1'b0;
        bus.miss_addr_fifo_full_i = 1'b0;
        bus.fill_done_i           = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(bus.miss_req_ready_o), 32'd0);
        chk("rst_arvalid", 32'(bus.mem_arvalid_o), 32'd0);
        chk("rst_wren", 32'(bus.miss_addr_fifo_wren_o), 32'd0);
        chk("rst_araddr", bus.mem_araddr_o, 32'd0);
        chk("rst_cnt", 32'(dut.outst_cnt), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(bus.miss_req_ready_o), 32'd1);

        // Single miss: push in accept cycle, AR next cycle with wrap attributes
        accept_miss(32'h0001_2368, 1'b0);
        chk("single_araddr", bus.mem_araddr_o, 32'h0001_2368);
        ar_handshake();
        chk("single_idle_ready", 32'(bus.miss_req_ready_o), 32'd1);
        chk("cnt_1", 32'(dut.outst_cnt), 32'd1);

        // Misaligned address, arready withheld for 5 cycles while valid held
        accept_miss(32'h1234_567D, 1'b0);
        bus.miss_req_valid_i = 1'b1;
        bus.miss_req_addr_i  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_arvalid", 32'(bus.mem_arvalid_o), 32'd1);
            chk("stall_araddr", bus.mem_araddr_o, 32'h1234_5678);
            chk("stall_arlen", 32'(bus.mem_arlen_o), 32'd7);
            chk("stall_ready", 32'(bus.miss_req_ready_o), 32'd0);
            chk("stall_wren", 32'(bus.miss_addr_fifo_wren_o), 32'd0);
            tick();
        end
        bus.miss_req_valid_i = 1'b0;
        ar_handshake();
        chk("stall_idle_ready", 32'(bus.miss_req_ready_o), 32'd1);
        chk("cnt_2", 32'(dut.outst_cnt), 32'd2);

        // Accept and fill_done together at cnt=2
        accept_miss(32'h8000_00FD, 1'b1);
        chk("same_cycle_cnt", 32'(dut.outst_cnt), 32'd2);
        ar_handshake();

        // Fill up to MAX_OUTST then release one slot
        accept_miss(32'h0000_1000, 1'b0);
        ar_handshake();
        accept_miss(32'h0000_2044, 1'b0);
        ar_handshake();
        chk("cnt_full", 32'(dut.outst_cnt), 32'd4);
        bus.miss_req_valid_i = 1'b1;
        bus.miss_req_addr_i  = 32'h0000_3008;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("max_ready", 32'(bus.miss_req_ready_o), 32'd0);
            chk("max_wren", 32'(bus.miss_addr_fifo_wren_o), 32'd0);
            tick();
        end
        fill_pulse();
        chk("max_release_cnt", 32'(dut.outst_cnt), 32'd3);
        accept_miss(32'h0000_3008, 1'b0);
        ar_handshake();
        for (int i = 0; i < 4; i++) fill_pulse();
        chk("drained_cnt", 32'(dut.outst_cnt), 32'd0);

        // FIFO full blocks acceptance until it clears
        bus.miss_addr_fifo_full_i = 1'b1;
        bus.miss_req_valid_i      = 1'b1;
        bus.miss_req_addr_i       = 32'hCAFE_0010;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("full_ready", 32'(bus.miss_req_ready_o), 32'd0);
            chk("full_wren", 32'(bus.miss_addr_fifo_wren_o), 32'd0);
            tick();
        end
        bus.miss_addr_fifo_full_i = 1'b0;
        accept_miss(32'hCAFE_0010, 1'b0);
        ar_handshake();
        chk("full_cnt", 32'(dut.outst_cnt), 32'd1);

        // Reset in AR_REQ aborts the pending AR
        accept_miss(32'h0BAD_F00F, 1'b0);
        void'(ar_q.pop_back());
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(bus.miss_req_ready_o), 32'd0);
        tick();
        chk("rst_mid_arvalid", 32'(bus.mem_arvalid_o), 32'd0);
        chk("rst_mid_cnt", 32'(dut.outst_cnt), 32'd0);
        chk("rst_mid_araddr", bus.mem_araddr_o, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_mid_rel_ready", 32'(bus.miss_req_ready_o), 32'd1);
        fill_pulse();
        chk("spurious_fill_cnt", 32'(dut.outst_cnt), 32'd0);
        chk("spurious_fill_ready", 32'(bus.miss_req_ready_o), 32'd1);
        chk("sb_empty", 32'(ar_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_miss_req_unit.md
CC_MISS_REQ_UNIT -- requirements
Module: cc_miss_req_unit

Interface
REQ-001 Parameter MAX_OUTST, default 4, SHALL set the maximum number of line fills in flight (1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 miss_req_valid_i  input  1  SHALL mean a miss request is present.
REQ-005 miss_req_addr_i  input  32  SHALL carry the byte address of the missed access.
REQ-006 miss_req_ready_o  output  1  SHALL mean a request can be accepted this cycle.
REQ-007 mem_arvalid_o / mem_arready_i  output/input  1/1  SHALL form the AXI AR handshake.
REQ-008 mem_araddr_o  output  32  SHALL carry the burst start address.
REQ-009 mem_arlen_o  output  4, mem_arsize_o  output  3, mem_arburst_o  output  2  SHALL carry the AXI burst attributes.
REQ-010 miss_addr_fifo_full_i  input  1  SHALL mean the miss-address FIFO cannot accept a push.
REQ-011 miss_addr_fifo_wren_o  output  1, miss_addr_fifo_wdata_o  output  32  SHALL push the miss address to the FIFO that feeds the fill stage.
REQ-012 fill_done_i  input  1  SHALL pulse once per completed line write to the SRAM (the fill stage's write enable).

Function
REQ-013 The FSM SHALL have two states: IDLE and AR_REQ.
REQ-014 miss_req_ready_o SHALL be 1 iff state==IDLE, miss_addr_fifo_full_i==0 and outst_cnt<MAX_OUTST.
REQ-015 miss_req_ready_o SHALL NOT depend combinationally on miss_req_valid_i or mem_arready_i.
REQ-016 A request SHALL be accepted when miss_req_valid_i and miss_req_ready_o are both 1 in the same cycle.
REQ-017 On acceptance, miss_addr_fifo_wren_o SHALL be 1 in that same cycle, with wdata equal to miss_req_addr_i unmodified.
REQ-018 miss_addr_fifo_wren_o SHALL be 0 in every other cycle.
REQ-019 On acceptance, mem_araddr_o SHALL be registered as {addr[31:3],3'b000} to give critical-doubleword-first ordering.
REQ-020 On acceptance, the state SHALL move to AR_REQ on the next cycle.
REQ-021 mem_arvalid_o SHALL be 1 exactly while the state is AR_REQ, so it asserts one cycle after acceptance.
REQ-022 mem_araddr_o, mem_arlen_o, mem_arsize_o and mem_arburst_o SHALL hold stable while mem_arvalid_o=1 and mem_arready_i=0.
REQ-023 mem_arlen_o SHALL be 4'd7 (8 beats), mem_arsize_o SHALL be 3'b011 (8 B), and mem_arburst_o SHALL be 2'b10 (WRAP), constant whenever mem_arvalid_o=1.
REQ-024 In AR_REQ with mem_arready_i=1, the state SHALL return to IDLE; no acceptance SHALL occur in that cycle, giving at most 1 request per 2 cycles.
REQ-025 outst_cnt SHALL be 4 bits wide: +1 on acceptance, -1 on fill_done_i, unchanged when both occur in the same cycle.
REQ-026 fill_done_i with outst_cnt==0 and no acceptance SHALL leave outst_cnt at 0 (saturate, no wrap).
REQ-027 Acceptance with outst_cnt==MAX_OUTST is impossible by REQ-014; outst_cnt SHALL never exceed MAX_OUTST.
REQ-028 The FIFO address order SHALL equal the AR issue order, because there is one request in flight on AR at a time.

Reset
REQ-029 While rst=1: state=IDLE, outst_cnt=0, mem_araddr_o=0, mem_arvalid_o=0, miss_addr_fifo_wren_o=0, miss_req_ready_o=0.
REQ-030 Reset asserted during AR_REQ SHALL abort the pending AR; mem_arvalid_o SHALL be 0 from the first reset cycle.
REQ-031 After reset releases, miss_req_ready_o SHALL be 1 in the first cycle if the FIFO is not full.

Structure
REQ-032 The AXI burst encodings (FIXED/INCR/WRAP), CC_ARLEN=7, CC_ARSIZE=3 and the default MAX_OUTST SHALL live in shared package cc_pkg, reused by the fill stage.
REQ-033 The block SHALL be a single module with no sub-module; the outstanding counter and FSM SHALL be inline.
REQ-034 All outputs except miss_req_ready_o and miss_addr_fifo_wren_o/wdata SHALL be driven directly from flops.

Verification
REQ-035 Bench SHALL cover: single miss at addr 0x0001_2368 -> FIFO push of 0x0001_2368 in the accept cycle; next cycle arvalid=1, araddr=0x0001_2368, arlen=7, arsize=3, arburst=2.
REQ-036 Bench SHALL cover: arready held 0 for 5 cycles -> araddr and attributes stable; ready=0 throughout; IDLE on the cycle after arready=1.
REQ-037 Bench SHALL cover: MAX_OUTST=4 with 4 accepted misses and no fill_done -> ready=0 with valid held; one fill_done pulse -> ready=1 on the next cycle.
REQ-038 Bench SHALL cover: acceptance and fill_done in the same cycle with outst_cnt=2 -> outst_cnt stays 2.
REQ-039 Bench SHALL cover: miss_addr_fifo_full_i=1 with valid=1 -> ready=0 and no wren; full deasserts -> accepted that cycle.
REQ-040 Bench SHALL cover: rst=1 asserted mid-AR_REQ -> arvalid=0 and outst_cnt=0 in the next cycle; a spurious fill_done at cnt=0 -> cnt stays 0.
